// File: rtl/sysu_gate_pipe.sv
// rtl/sysu_gate_pipe.sv - pipelined selectable bitwise gate with valid/ready flow control
module sysu_gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int NUM_IN  = 2,
    parameter int LATENCY = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_IN*WIDTH-1:0]      A,
    input  logic [2:0]                   MODE,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [WIDTH-1:0]             Y,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [$clog2(LATENCY+1)-1:0] COUNT
);

    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [2:0] MODE_OR   = 3'd0;
    localparam logic [2:0] MODE_AND  = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_NAND = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_PASS = 3'd6;

    logic [WIDTH-1:0]   r_data [LATENCY];
    logic [LATENCY-1:0] r_valid;
    logic [CW-1:0]      r_count;
    logic [LATENCY-1:0] w_ready;
    logic [WIDTH-1:0]   w_or;
    logic [WIDTH-1:0]   w_and;
    logic [WIDTH-1:0]   w_xor;
    logic [WIDTH-1:0]   w_func;
    logic               w_accept;
    logic               w_consume;

    // Reduce all operands once, then pick (and optionally invert) by MODE
    always_comb begin
        w_or  = '0;
        w_and = '1;
        w_xor = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_or  = w_or  | A[i*WIDTH +: WIDTH];
            w_and = w_and & A[i*WIDTH +: WIDTH];
            w_xor = w_xor ^ A[i*WIDTH +: WIDTH];
        end
        case (MODE)
            MODE_OR:   w_func = w_or;
            MODE_AND:  w_func = w_and;
            MODE_XOR:  w_func = w_xor;
            MODE_NOR:  w_func = ~w_or;
            MODE_NAND: w_func = ~w_and;
            MODE_XNOR: w_func = ~w_xor;
            MODE_PASS: w_func = A[WIDTH-1:0];
            default:   w_func = '0;
        endcase
    end

    // Stage i is ready when any stage from i to the end has a hole, or the
    // output is being consumed; written flat to avoid a self-referencing chain
    for (genvar g = 0; g < LATENCY; g++) begin : g_ready
        assign w_ready[g] = OUT_READY | ~(&r_valid[LATENCY-1:g]);
    end

    assign IN_READY  = w_ready[0];
    assign w_accept  = IN_VALID & w_ready[0];
    assign w_consume = r_valid[LATENCY-1] & OUT_READY;
    assign Y         = r_data[LATENCY-1];
    assign OUT_VALID = r_valid[LATENCY-1];
    assign COUNT     = r_count;

    // Stage registers: valid follows upstream when ready, data only on a real entry
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_valid[0] <= IN_VALID;
                if (IN_VALID) begin
                    r_data[0] <= w_func;
                end
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end
    end

    // Occupancy: accept adds one, consume removes one, both together cancel
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_accept && !w_consume) begin
            r_count <= r_count + CW'(1);
        end else if (w_consume && !w_accept) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: tb/tb_sysu_gate_pipe.sv
// tb/tb_sysu_gate_pipe.sv - scoreboard bench for sysu_gate_pipe at latencies 1, 3 and 4
module tb_sysu_gate_pipe;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    // dut1: WIDTH 8, NUM_IN 2, LATENCY 1
    logic [15:0] a1 = '0;
    logic [2:0]  m1 = '0;
    logic        iv1 = 1'b0, or1 = 1'b1, ir1, ov1;
    logic [7:0]  y1;
    logic [0:0]  c1;
    // dut3: WIDTH 8, NUM_IN 4, LATENCY 3
    logic [31:0] a3 = '0;
    logic [2:0]  m3 = '0;
    logic        iv3 = 1'b0, or3 = 1'b1, ir3, ov3;
    logic [7:0]  y3;
    logic [1:0]  c3;
    // dut4: WIDTH 8, NUM_IN 2, LATENCY 4
    logic [15:0] a4 = '0;
    logic [2:0]  m4 = '0;
    logic        iv4 = 1'b0, or4 = 1'b1, ir4, ov4;
    logic [7:0]  y4;
    logic [2:0]  c4;

    sysu_gate_pipe #(.WIDTH(8), .NUM_IN(2), .LATENCY(1)) dut1 (
        .CLK(CLK), .RST(RST), .A(a1), .MODE(m1), .IN_VALID(iv1), .IN_READY(ir1),
        .Y(y1), .OUT_VALID(ov1), .OUT_READY(or1), .COUNT(c1));
    sysu_gate_pipe #(.WIDTH(8), .NUM_IN(4), .LATENCY(3)) dut3 (
        .CLK(CLK), .RST(RST), .A(a3), .MODE(m3), .IN_VALID(iv3), .IN_READY(ir3),
        .Y(y3), .OUT_VALID(ov3), .OUT_READY(or3), .COUNT(c3));
    sysu_gate_pipe #(.WIDTH(8), .NUM_IN(2), .LATENCY(4)) dut4 (
        .CLK(CLK), .RST(RST), .A(a4), .MODE(m4), .IN_VALID(iv4), .IN_READY(ir4),
        .Y(y4), .OUT_VALID(ov4), .OUT_READY(or4), .COUNT(c4));

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q1 [$];
    logic [7:0] q3 [$];
    logic [7:0] q4 [$];

    // A0=F0, A1=3C for MODE 0..7
    logic [7:0] mode_exp [8] = '{8'hFC, 8'h30, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'hF0, 8'h00};
    // operands AA/3C/0F/FF (operand 0 = AA), modes 1,2,4,5,6
    logic [2:0] s_mode [5] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [7:0] s_exp  [5] = '{8'h08, 8'h66, 8'hF7, 8'h99, 8'hAA};
    // backpressure entries on the same operands, modes 0,2,6,5
    logic [2:0] b_mode [4] = '{3'd0, 3'd2, 3'd6, 3'd5};
    logic [7:0] b_exp  [4] = '{8'hFF, 8'h66, 8'hAA, 8'h99};
    // bubble entries on F0/3C, modes 2,0,1,3
    logic [2:0] u_mode [4] = '{3'd2, 3'd0, 3'd1, 3'd3};
    logic [7:0] u_exp  [4] = '{8'hCC, 8'hFC, 8'h30, 8'h03};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic at_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic unexpected(input string nm, input logic [7:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected result %0h with empty queue at %0t", nm, act, $time);
    endtask

    // Monitors: pop and compare whatever each DUT hands over this cycle
    always @(negedge CLK) begin
        if (!RST && ov1 && or1) begin
            if (q1.size() == 0) unexpected("dut1_out", y1);
            else chk("dut1_out", {24'd0, y1}, {24'd0, q1.pop_front()});
        end
        if (!RST && ov3 && or3) begin
            if (q3.size() == 0) unexpected("dut3_out", y3);
            else chk("dut3_out", {24'd0, y3}, {24'd0, q3.pop_front()});
        end
        if (!RST && ov4 && or4) begin
            if (q4.size() == 0) unexpected("dut4_out", y4);
            else chk("dut4_out", {24'd0, y4}, {24'd0, q4.pop_front()});
        end
    end

    initial begin
        // reset state while RST is held
        #3;
        chk("rst_y1", {24'd0, y1}, 32'h0);
        chk("rst_ov1", {31'd0, ov1}, 32'h0);
        chk("rst_c1", {31'd0, c1}, 32'h0);
        chk("rst_c4", {29'd0, c4}, 32'h0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ir1", {31'd0, ir1}, 32'h1);
        chk("idle_ir3", {31'd0, ir3}, 32'h1);
        chk("idle_ir4", {31'd0, ir4}, 32'h1);

        // all modes through LATENCY 1, back to back
        a1 = {8'h3C, 8'hF0};
        for (int k = 0; k < 9; k++) begin
            at_edge();
            if (k < 8) begin
                m1 = 3'(k);
                iv1 = 1'b1;
                q1.push_back(mode_exp[k]);
            end else begin
                iv1 = 1'b0;
            end
            @(negedge CLK);
            if (k > 0) begin
                chk("l1_ov", {31'd0, ov1}, 32'h1);
                chk("l1_y", {24'd0, y1}, {24'd0, mode_exp[k-1]});
            end
        end
        at_edge();
        @(negedge CLK);
        chk("l1_idle_ov", {31'd0, ov1}, 32'h0);

        // four operands, latency 3
        at_edge();
        a3 = {8'h08, 8'h04, 8'h02, 8'h01};
        m3 = 3'd0;
        iv3 = 1'b1;
        q3.push_back(8'h0F);
        at_edge();
        iv3 = 1'b0;
        @(negedge CLK);
        chk("l3_ov_t", {31'd0, ov3}, 32'h0);
        chk("l3_cnt_t", {30'd0, c3}, 32'h1);
        at_edge();
        @(negedge CLK);
        chk("l3_ov_t1", {31'd0, ov3}, 32'h0);
        at_edge();
        @(negedge CLK);
        chk("l3_ov_t2", {31'd0, ov3}, 32'h1);
        chk("l3_y_t2", {24'd0, y3}, 32'h0F);

        // stream of five, must emerge on consecutive cycles
        a3 = {8'hFF, 8'h0F, 8'h3C, 8'hAA};
        for (int c = 0; c < 8; c++) begin
            at_edge();
            if (c < 5) begin
                m3 = s_mode[c];
                iv3 = 1'b1;
                q3.push_back(s_exp[c]);
            end else begin
                iv3 = 1'b0;
            end
            @(negedge CLK);
            if (c >= 3) begin
                chk("l3_stream_ov", {31'd0, ov3}, 32'h1);
                chk("l3_stream_y", {24'd0, y3}, {24'd0, s_exp[c-3]});
            end
        end

        // backpressure: fill, hold the fourth, then consume and accept together
        for (int k = 0; k < 4; k++) begin
            at_edge();
            or3 = 1'b0;
            m3 = b_mode[k];
            iv3 = 1'b1;
            q3.push_back(b_exp[k]);
            @(negedge CLK);
            chk("bp_cnt", {30'd0, c3}, 32'(k));
        end
        chk("bp_full_ir", {31'd0, ir3}, 32'h0);
        chk("bp_full_y", {24'd0, y3}, 32'hFF);
        at_edge();
        @(negedge CLK);
        chk("bp_hold_cnt", {30'd0, c3}, 32'h3);
        chk("bp_hold_ir", {31'd0, ir3}, 32'h0);
        chk("bp_hold_y", {24'd0, y3}, 32'hFF);
        chk("bp_hold_ov", {31'd0, ov3}, 32'h1);
        at_edge();
        or3 = 1'b1;
        @(negedge CLK);
        chk("bp_chain_ir", {31'd0, ir3}, 32'h1);
        at_edge();
        or3 = 1'b0;
        iv3 = 1'b0;
        @(negedge CLK);
        chk("bp_swap_cnt", {30'd0, c3}, 32'h3);
        chk("bp_swap_y", {24'd0, y3}, 32'h66);
        for (int k = 0; k < 5; k++) begin
            at_edge();
            or3 = 1'b1;
        end
        @(negedge CLK);
        chk("bp_drain_cnt", {30'd0, c3}, 32'h0);

        // bubble collapse at latency 4 with the output stalled
        a4 = {8'h3C, 8'hF0};
        at_edge();
        or4 = 1'b0;
        m4 = u_mode[0];
        iv4 = 1'b1;
        q4.push_back(u_exp[0]);
        at_edge();
        iv4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) at_edge();
            @(negedge CLK);
            chk("bub_cnt", {29'd0, c4}, 32'h1);
            chk("bub_ir", {31'd0, ir4}, 32'h1);
            chk("bub_ov", {31'd0, ov4}, (k == 3) ? 32'h1 : 32'h0);
        end
        chk("bub_y", {24'd0, y4}, 32'hCC);
        for (int k = 1; k < 5; k++) begin
            at_edge();
            if (k < 4) begin
                m4 = u_mode[k];
                iv4 = 1'b1;
                q4.push_back(u_exp[k]);
            end else begin
                iv4 = 1'b0;
            end
            @(negedge CLK);
            chk("bub_fill_cnt", {29'd0, c4}, 32'(k));
            chk("bub_fill_ir", {31'd0, ir4}, (k == 4) ? 32'h0 : 32'h1);
        end
        for (int k = 0; k < 6; k++) begin
            at_edge();
            or4 = 1'b1;
        end

        // reset with three entries in flight
        for (int k = 0; k < 4; k++) begin
            at_edge();
            m4 = 3'(k);
            iv4 = (k < 3);
        end
        @(negedge CLK);
        chk("mid_cnt", {29'd0, c4}, 32'h3);
        chk("mid_y_before", {24'd0, y4}, 32'h03);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_cnt", {29'd0, c4}, 32'h0);
        chk("mid_rst_ov", {31'd0, ov4}, 32'h0);
        chk("mid_rst_y4", {24'd0, y4}, 32'h0);
        chk("mid_rst_y3", {24'd0, y3}, 32'h0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            at_edge();
            @(negedge CLK);
            chk("post_rst_ov", {31'd0, ov4}, 32'h0);
        end

        // a fresh entry still flows after reset
        at_edge();
        m4 = 3'd5;
        iv4 = 1'b1;
        q4.push_back(8'h33);
        at_edge();
        iv4 = 1'b0;
        for (int k = 0; k < 6; k++) at_edge();
        @(negedge CLK);

        chk("q1_empty", 32'(q1.size()), 32'h0);
        chk("q3_empty", 32'(q3.size()), 32'h0);
        chk("q4_empty", 32'(q4.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
